modn_tick_counter: RTL and testbench
====================================

Name: modn_tick_counter

Overview:
- Parametrised successor to the 1 Hz mod-8 up-counter path.
- A single-clock block that replaces the derived-clock divider with an internal prescaler producing a one-cycle tick enable.
- The counter is modulo-N, up/down, with synchronous load, free-run or one-shot mode, a terminal-count pulse, and an LED hold output.
- Sits between the board clock and the display/LED pins in top-level exercise designs.

Parameters:
- TICK_DIV, 50000000: CLK cycles per counting tick; must be >= 1, and 1 means a tick every cycle.
- MODULUS, 8: count range is 0..MODULUS-1; must be >= 2.
- WIDTH, 3: width of Q and D; must be >= clog2(MODULUS).
- LED_TICKS, 1: number of ticks LED stays high after a TC; 0 means LED toggles on every TC.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable, qualifies ticks.
- DIR  in  1  1 = count up, 0 = count down.
- ONESHOT  in  1  0 = free-run (wrap), 1 = stop at terminal value.
- START  in  1  restarts counting from the HALT state.
- LOAD  in  1  synchronous load strobe.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current count.
- TC  out  1  one-cycle terminal-count pulse.
- LED  out  1  visual indicator driven by TC.
- BUSY  out  1  high while in RUN.

Behaviour:
- Clock and reset: one clock, CLK; RST is synchronous and active-high. All state is updated on the rising edge of CLK.
- Reset values: Q=0, TC=0, LED=0, BUSY=1, prescaler=0, LED hold counter=0, state=RUN.
- Priority per cycle: RST > LOAD > START > tick step.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; it runs regardless of EN.
  - tick = (prescaler == TICK_DIV-1), high for one cycle.
  - Cleared to 0 by RST and LOAD.
- FSM states: RUN and HALT.
- RUN, on a cycle with tick && EN:
  - Up: Q+1. When Q == MODULUS-1, free-run mode wraps Q to 0.
  - Down: Q-1. When Q == 0, free-run mode wraps Q to MODULUS-1.
  - Free-run: TC=1 in the cycle Q takes the wrapped value.
  - One-shot: when the step makes Q reach the terminal value (MODULUS-1 up, 0 down), TC=1 in that cycle, state goes to HALT and BUSY goes to 0.
  - One-shot with Q already at terminal: the next tick asserts TC, leaves Q unchanged and enters HALT.
- HALT:
  - Q is frozen and ticks are ignored.
  - START=1: Q reloads to 0 (DIR=1) or MODULUS-1 (DIR=0), state goes to RUN and BUSY goes to 1, all on the next edge. TC is not asserted.
  - A change on ONESHOT alone does not leave HALT.
- START while in RUN: ignored.
- LOAD, in any state:
  - Q <= D if D < MODULUS, otherwise Q <= MODULUS-1 (clamp).
  - State goes to RUN; prescaler is cleared; TC=0 in that cycle.
  - The LED hold is unaffected.
- Timing of mode inputs:
  - DIR and ONESHOT are sampled only on tick cycles.
  - A DIR change takes effect on the next tick; no glitch step occurs.
- Latency: Q and TC are registered, so both update on the edge following the tick cycle. TC stays aligned with the new Q.
- LED:
  - LED_TICKS > 0: TC sets LED=1 and loads the hold counter with LED_TICKS. Each tick decrements the counter; LED clears when it reaches 0.
  - A TC while LED is high reloads the counter.
  - The tick coincident with TC does not decrement.
  - LED_TICKS = 0: LED toggles on each TC.
- Arithmetic: Q never leaves 0..MODULUS-1, including when MODULUS is not a power of two.

Test Plan:
- Bench parameters: TICK_DIV=4, MODULUS=10, WIDTH=4, LED_TICKS=2.
- Reset and free-run up: RST for 2 cycles, EN=1, DIR=1, ONESHOT=0 -> Q steps every 4 CLKs through 0..9, then 0; TC is high exactly 1 cycle when Q goes 9->0; LED is high for 2 ticks (8 CLKs) afterwards.
- Down wrap: DIR=0 from Q=1 -> Q goes 1, 0, 9; TC pulses on the 0->9 transition; Q never shows 10..15.
- One-shot up: ONESHOT=1, Q=7 -> Q goes 8, then 9 with TC and BUSY=0; further ticks hold Q=9; START -> Q=0 and BUSY=1 next cycle, with no TC.
- Load and clamp: LOAD with D=5 -> Q=5 next cycle and the prescaler restarts (next step 4 CLKs later); LOAD with D=13 -> Q=9; LOAD and START together in HALT -> LOAD wins.
- Enable, reset mid-run: EN=0 for 20 CLKs -> Q constant; RST asserted mid-count while LED=1 -> Q=0, LED=0, TC=0 on the next edge.
- Degenerate tick: TICK_DIV=1, LED_TICKS=0 -> Q steps every cycle; LED toggles on each wrap, every 10 cycles.

Source files
------------

// File: rtl/modn_tick_counter.sv
// Single-clock modulo-N up/down counter advanced by an internal prescaler tick.
// Supports free-run/one-shot, synchronous load with clamp, a TC pulse and an LED hold.
module modn_tick_counter #(
    parameter int TICK_DIV  = 50000000,
    parameter int MODULUS   = 8,
    parameter int WIDTH     = 3,
    parameter int LED_TICKS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIR,
    input  logic             ONESHOT,
    input  logic             START,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             LED,
    output logic             BUSY
);

    // state | meaning
    // RUN   | counting on qualified ticks, BUSY=1
    // HALT  | one-shot reached terminal; Q frozen until START or LOAD
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (LED_TICKS > 0) ? $clog2(LED_TICKS + 1) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] Q_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [LW-1:0]    LED_LOAD  = LW'(LED_TICKS);

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [WIDTH-1:0] q_nxt, step_q, term_val;
    logic             tc_nxt, led_nxt, tick, at_term;
    logic [LW-1:0]    hold, hold_nxt;

    assign tick = (presc == PRESC_MAX);
    assign BUSY = (state == RUN);

    always_comb begin
        state_nxt = state;
        q_nxt     = Q;
        tc_nxt    = 1'b0;
        presc_nxt = tick ? '0 : presc + PW'(1);
        term_val  = DIR ? Q_MAX : '0;
        at_term   = (Q == term_val);
        // Explicit wrap keeps Q inside 0..MODULUS-1 for non power-of-two moduli
        if (DIR)
            step_q = (Q == Q_MAX) ? '0 : Q + WIDTH'(1);
        else
            step_q = (Q == '0) ? Q_MAX : Q - WIDTH'(1);

        if (LOAD) begin
            q_nxt     = (D > Q_MAX) ? Q_MAX : D;
            state_nxt = RUN;
            presc_nxt = '0;
        end else if (START && state == HALT) begin
            q_nxt     = DIR ? '0 : Q_MAX;
            state_nxt = RUN;
        end else if (state == RUN && tick && EN) begin
            if (ONESHOT) begin
                if (!at_term)
                    q_nxt = step_q;
                if (at_term || step_q == term_val) begin
                    tc_nxt    = 1'b1;
                    state_nxt = HALT;
                end
            end else begin
                q_nxt  = step_q;
                tc_nxt = at_term;
            end
        end
    end

    // A TC edge takes precedence over the hold decrement on the same tick
    always_comb begin
        led_nxt  = LED;
        hold_nxt = hold;
        if (LED_TICKS == 0) begin
            if (tc_nxt)
                led_nxt = ~LED;
        end else if (tc_nxt) begin
            led_nxt  = 1'b1;
            hold_nxt = LED_LOAD;
        end else if (tick && hold != '0) begin
            hold_nxt = hold - LW'(1);
            if (hold == LW'(1))
                led_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            presc <= '0;
            Q     <= '0;
            TC    <= 1'b0;
            LED   <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
            Q     <= q_nxt;
            TC    <= tc_nxt;
            LED   <= led_nxt;
            hold  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_modn_tick_counter.sv
// Scoreboard bench for modn_tick_counter: two parameter sets share one stimulus
// stream; an arithmetic reference model predicts every cycle's outputs.
module tb_modn_tick_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, dir, oneshot, start, load;
    logic [3:0] d;
    logic [3:0] q0, q1;
    logic       tc0, tc1, led0, led1, busy0, busy1;

    modn_tick_counter #(.TICK_DIV(4), .MODULUS(10), .WIDTH(4), .LED_TICKS(2)) dut (
        .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .ONESHOT(oneshot), .START(start),
        .LOAD(load), .D(d), .Q(q0), .TC(tc0), .LED(led0), .BUSY(busy0));

    modn_tick_counter #(.TICK_DIV(1), .MODULUS(10), .WIDTH(4), .LED_TICKS(0)) dut_fast (
        .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .ONESHOT(oneshot), .START(start),
        .LOAD(load), .D(d), .Q(q1), .TC(tc1), .LED(led1), .BUSY(busy1));

    typedef struct {int presc; int q; bit halted; bit tc; bit led; int hold;} mstate_t;
    typedef struct {int q; bit tc; bit led; bit busy;} exp_t;

    mstate_t m0, m1;
    exp_t    sb0[$], sb1[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    function automatic mstate_t mstep(mstate_t s, bit r, bit e, bit up, bit os, bit st,
                                      bit ld, int dv, int tdiv, int mod, int lt);
        mstate_t n;
        bit      tick;
        int      term;
        n    = s;
        n.tc = 1'b0;
        if (r) begin
            n = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
            return n;
        end
        tick    = (s.presc == tdiv - 1);
        n.presc = (s.presc + 1) % tdiv;
        term    = up ? mod - 1 : 0;
        if (ld) begin
            n.q      = (dv < mod) ? dv : mod - 1;
            n.halted = 1'b0;
            n.presc  = 0;
        end else if (st && s.halted) begin
            n.q      = up ? 0 : mod - 1;
            n.halted = 1'b0;
        end else if (!s.halted && tick && e) begin
            if (os) begin
                if (s.q != term)
                    n.q = up ? s.q + 1 : s.q - 1;
                if (n.q == term) begin
                    n.tc     = 1'b1;
                    n.halted = 1'b1;
                end
            end else begin
                n.q  = up ? (s.q + 1) % mod : (s.q + mod - 1) % mod;
                n.tc = (s.q == term);
            end
        end
        if (lt == 0) begin
            if (n.tc) n.led = !s.led;
        end else if (n.tc) begin
            n.led  = 1'b1;
            n.hold = lt;
        end else if (tick && s.hold > 0) begin
            n.hold = s.hold - 1;
            if (n.hold == 0) n.led = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, expv);
        end
    endtask

    // Predict the next edge from the inputs now on the pins, then move to the next negedge
    task automatic cyc(int n);
        for (int i = 0; i < n; i++) begin
            m0 = mstep(m0, rst, en, dir, oneshot, start, load, int'(d), 4, 10, 2);
            m1 = mstep(m1, rst, en, dir, oneshot, start, load, int'(d), 1, 10, 0);
            sb0.push_back('{m0.q, m0.tc, m0.led, !m0.halted});
            sb1.push_back('{m1.q, m1.tc, m1.led, !m1.halted});
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                chk("q_div4", 32'(q0), 32'(e.q));
                chk("tc_div4", 32'(tc0), 32'(e.tc));
                chk("led_div4", 32'(led0), 32'(e.led));
                chk("busy_div4", 32'(busy0), 32'(e.busy));
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                chk("q_div1", 32'(q1), 32'(e.q));
                chk("tc_div1", 32'(tc1), 32'(e.tc));
                chk("led_div1", 32'(led1), 32'(e.led));
                chk("busy_div1", 32'(busy1), 32'(e.busy));
            end
        end
    end

    initial begin
        m0 = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
        m1 = m0;
        rst = 1'b1; en = 1'b1; dir = 1'b1; oneshot = 1'b0;
        start = 1'b0; load = 1'b0; d = 4'd0;
        @(negedge clk);

        // reset then free-run up through a full wrap and LED hold
        cyc(2);
        rst = 1'b0;
        cyc(60);

        // down wrap from Q=1
        load = 1'b1; d = 4'd1; cyc(1);
        load = 1'b0; dir = 1'b0; cyc(16);

        // one-shot up from 7, halt, restart
        dir = 1'b1; oneshot = 1'b1; load = 1'b1; d = 4'd7; cyc(1);
        load = 1'b0; cyc(20);
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(6);

        // load, clamp, load beating start in HALT
        oneshot = 1'b0; load = 1'b1; d = 4'd5; cyc(1);
        load = 1'b0; cyc(6);
        load = 1'b1; d = 4'd13; cyc(1);
        load = 1'b0; cyc(3);
        oneshot = 1'b1; load = 1'b1; d = 4'd8; cyc(1);
        load = 1'b0; cyc(12);
        load = 1'b1; start = 1'b1; d = 4'd3; cyc(1);
        load = 1'b0; start = 1'b0; cyc(4);

        // enable low, then reset while LED is lit
        oneshot = 1'b0; en = 1'b0; cyc(20);
        en = 1'b1; load = 1'b1; d = 4'd9; cyc(1);
        load = 1'b0; cyc(6);
        rst = 1'b1; cyc(1);
        rst = 1'b0; cyc(4);

        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(63) == 0);
            load  = ($urandom_range(15) == 0);
            start = ($urandom_range(7) == 0);
            en    = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) dir = ~dir;
            if ($urandom_range(31) == 0) oneshot = ~oneshot;
            d = 4'($urandom_range(15));
            cyc(1);
        end

        rst = 1'b0; load = 1'b0; start = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
